// File: rtl/ro_mon_pkg.sv
// Shared types and default sizing for the ring-oscillator monitor sequencer.
// AVG_WINDOWS is used only when RO_MON_AVG_EN is defined.
package ro_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        MEASURE,
        FIN
    } ro_state_e;

    localparam int unsigned AVG_WINDOWS    = 4;

    localparam int unsigned DEF_N_RO       = 4;
    localparam int unsigned DEF_SEL_W      = 2;
    localparam int unsigned DEF_CNT_W      = 16;
    localparam int unsigned DEF_WIN_W      = 16;
    localparam int unsigned DEF_SETTLE_CYC = 8;

endpackage

// File: rtl/ro_mon_sync.sv
// Two-flop synchroniser for an asynchronous RO output, followed by a
// previous-value flop that yields a one-cycle rising-edge strobe.
module ro_mon_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_edge
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_edge = r_sync & ~r_prev;

endmodule

// File: rtl/ro_mon_ctrl.sv
// RO process-monitor sequencer: enable one RO, settle, count edges over a window.
// Define RO_MON_AVG_EN to average four back-to-back windows.
module ro_mon_ctrl
    import ro_mon_pkg::*;
#(
    parameter int unsigned N_RO       = DEF_N_RO,
    parameter int unsigned SEL_W      = DEF_SEL_W,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned WIN_W      = DEF_WIN_W,
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [SEL_W-1:0]  SEL,
    input  logic [WIN_W-1:0]  WIN_LEN,
    input  logic [N_RO-1:0]   RO_IN,
    output logic [N_RO-1:0]   RO_EN,
    output logic              BUSY,
    output logic              DONE,
    output logic [CNT_W-1:0]  COUNT,
    output logic              OVF
);

`ifdef RO_MON_AVG_EN
    localparam int unsigned NWIN  = AVG_WINDOWS;
    localparam int unsigned ACC_W = CNT_W + 2;
    localparam int unsigned SHIFT = 2;
`else
    localparam int unsigned NWIN  = 1;
    localparam int unsigned ACC_W = CNT_W;
    localparam int unsigned SHIFT = 0;
`endif
    localparam int unsigned ST_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    ro_state_e          r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [WIN_W-1:0]   r_win_len;
    logic [WIN_W-1:0]   r_win_cnt;
    logic [1:0]         r_win_idx;
    logic [ST_W-1:0]    r_settle;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf_acc;
    logic [N_RO-1:0]    r_ro_en;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovf;

    logic [N_RO-1:0]    w_sel_onehot;
    logic               w_sel_valid;
    logic               w_ro_mux;
    logic               w_edge;
    logic               w_acc_sat;
    logic               w_ovf_hit;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_win_last;
    logic               w_meas_last;

    // Muxing ahead of the synchroniser keeps a single sync chain for all ROs.
    always_comb begin
        w_sel_onehot = '0;
        w_ro_mux     = 1'b0;
        for (int unsigned i = 0; i < N_RO; i++) begin
            if (SEL == SEL_W'(i))
                w_sel_onehot[i] = 1'b1;
            if (r_sel == SEL_W'(i))
                w_ro_mux = RO_IN[i];
        end
    end

    assign w_sel_valid = |w_sel_onehot;

    ro_mon_sync u_sync (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_async (w_ro_mux),
        .o_edge  (w_edge)
    );

    always_comb begin
        w_acc_sat   = (r_acc == '1);
        w_ovf_hit   = w_edge & w_acc_sat;
        w_acc_next  = r_acc + ACC_W'(w_edge & ~w_acc_sat);
        w_win_last  = (r_win_cnt == r_win_len - 1'b1);
        w_meas_last = w_win_last && (r_win_idx == 2'(NWIN - 1));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_sel     <= '0;
            r_win_len <= '0;
            r_win_cnt <= '0;
            r_win_idx <= '0;
            r_settle  <= '0;
            r_acc     <= '0;
            r_ovf_acc <= 1'b0;
            r_ro_en   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (START) begin
                        r_sel     <= SEL;
                        r_win_len <= WIN_LEN;
                        r_win_cnt <= '0;
                        r_win_idx <= '0;
                        r_settle  <= '0;
                        r_acc     <= '0;
                        r_ovf_acc <= 1'b0;
                        r_count   <= '0;
                        r_ovf     <= 1'b0;
                        r_busy    <= 1'b1;
                        if (w_sel_valid) begin
                            r_ro_en <= w_sel_onehot;
                            r_state <= SETTLE;
                        end else begin
                            r_ro_en <= '0;
                            r_done  <= 1'b1;
                            r_state <= FIN;
                        end
                    end
                end
                SETTLE: begin
                    if (r_settle == ST_W'(SETTLE_CYC - 1)) begin
                        r_settle <= '0;
                        if (r_win_len == '0) begin
                            r_ro_en <= '0;
                            r_done  <= 1'b1;
                            r_state <= FIN;
                        end else begin
                            r_state <= MEASURE;
                        end
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                MEASURE: begin
                    r_acc     <= w_acc_next;
                    r_ovf_acc <= r_ovf_acc | w_ovf_hit;
                    if (w_win_last) begin
                        r_win_cnt <= '0;
                        r_win_idx <= r_win_idx + 1'b1;
                    end else begin
                        r_win_cnt <= r_win_cnt + 1'b1;
                    end
                    // The final edge of the last window still lands in COUNT/OVF.
                    if (w_meas_last) begin
                        r_count <= w_acc_next[SHIFT +: CNT_W];
                        r_ovf   <= r_ovf_acc | w_ovf_hit;
                        r_ro_en <= '0;
                        r_done  <= 1'b1;
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign RO_EN = r_ro_en;
    assign BUSY  = r_busy;
    assign DONE  = r_done;
    assign COUNT = r_count;
    assign OVF   = r_ovf;

endmodule

// File: tb/tb_ro_mon_ctrl.sv
// Directed bench for ro_mon_ctrl: vector table plus abort / re-start sequences.
// Expected DONE latency scales with RO_MON_AVG_EN.
module tb_ro_mon_ctrl;

    localparam int unsigned N_RO       = 4;
    localparam int unsigned SEL_W      = 3;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned WIN_W      = 16;
    localparam int unsigned SETTLE_CYC = 8;
`ifdef RO_MON_AVG_EN
    localparam int unsigned NWIN = 4;
`else
    localparam int unsigned NWIN = 1;
`endif
    localparam int unsigned TIMEOUT = 2000;

    logic              CLK = 1'b0;
    logic              RST;
    logic              START;
    logic [SEL_W-1:0]  SEL;
    logic [WIN_W-1:0]  WIN_LEN;
    logic [N_RO-1:0]   RO_IN = '0;
    logic [N_RO-1:0]   RO_EN;
    logic              BUSY;
    logic              DONE;
    logic [CNT_W-1:0]  COUNT;
    logic              OVF;

    ro_mon_ctrl #(
        .N_RO       (N_RO),
        .SEL_W      (SEL_W),
        .CNT_W      (CNT_W),
        .WIN_W      (WIN_W),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .SEL     (SEL),
        .WIN_LEN (WIN_LEN),
        .RO_IN   (RO_IN),
        .RO_EN   (RO_EN),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .COUNT   (COUNT),
        .OVF     (OVF)
    );

    always #5 CLK = ~CLK;

    // Square-wave RO models, period in CLK cycles; 0 holds the line low.
    int unsigned ro_per [N_RO] = '{default: 0};
    int unsigned cyc = 0;
    always @(negedge CLK) begin
        cyc = cyc + 1;
        for (int i = 0; i < N_RO; i++)
            RO_IN[i] = (ro_per[i] == 0) ? 1'b0 : ((cyc % ro_per[i]) < (ro_per[i] / 2));
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input logic [31:0] act, input int lo, input int hi);
        n_cmp++;
        if ($isunknown(act) || int'(act) < lo || int'(act) > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    typedef struct {
        logic [SEL_W-1:0] sel;
        int unsigned      win;
        int unsigned      per;
        int unsigned      lat;
        int               cmin;
        int               cmax;
        logic             ovf;
        logic [N_RO-1:0]  en;
    } vec_t;

    vec_t vecs [5];

    task automatic set_periods(input logic [SEL_W-1:0] sel, input int unsigned per);
        for (int i = 0; i < N_RO; i++)
            ro_per[i] = (32'(sel) == i) ? per : 6;
    endtask

    task automatic issue_start(input logic [SEL_W-1:0] sel, input int unsigned win);
        @(negedge CLK);
        SEL     = sel;
        WIN_LEN = WIN_W'(win);
        START   = 1'b1;
        @(posedge CLK);
        #1;
        START   = 1'b0;
        SEL     = 3'd6;
        WIN_LEN = 16'd3;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int unsigned n;
        int unsigned done_at;
        int unsigned en_bad;
        logic [CNT_W-1:0] cnt_seen;
        n = 0; done_at = 0; en_bad = 0;
        set_periods(v.sel, v.per);
        repeat (4) @(negedge CLK);
        issue_start(v.sel, v.win);
        while (n < TIMEOUT && done_at == 0) begin
            @(negedge CLK);
            n++;
            if (DONE === 1'b1)
                done_at = n;
            else if (BUSY !== 1'b1 || RO_EN !== v.en)
                en_bad++;
        end
        check({tag, " done_latency"}, done_at, v.lat);
        check({tag, " busy_en_during_run"}, en_bad, 0);
        if (done_at != 0) begin
            check({tag, " ro_en_at_done"}, RO_EN, 0);
            check({tag, " busy_at_done"}, BUSY, 1);
            check_rng({tag, " count"}, COUNT, v.cmin, v.cmax);
            check({tag, " ovf"}, OVF, v.ovf);
            cnt_seen = COUNT;
            @(negedge CLK);
            check({tag, " done_pulse_end"}, {BUSY, DONE}, 0);
            check({tag, " count_held"}, COUNT, cnt_seen);
        end
    endtask

    initial begin
        int unsigned n;
        int unsigned dones;
        int unsigned first_done;
        int unsigned en_bad;
        int unsigned lat_main;
        lat_main = 1 + SETTLE_CYC + 100 * NWIN;

        vecs[0] = '{sel: 3'd1, win: 100, per: 10, lat: lat_main,
                    cmin: 9, cmax: 11, ovf: 1'b0, en: 4'b0010};
        vecs[1] = '{sel: 3'd2, win: 0, per: 10, lat: 1 + SETTLE_CYC,
                    cmin: 0, cmax: 0, ovf: 1'b0, en: 4'b0100};
        vecs[2] = '{sel: 3'd0, win: 100, per: 4, lat: lat_main,
                    cmin: 15, cmax: 15, ovf: 1'b1, en: 4'b0001};
        vecs[3] = '{sel: 3'd5, win: 100, per: 10, lat: 1,
                    cmin: 0, cmax: 0, ovf: 1'b0, en: 4'b0000};
        vecs[4] = '{sel: 3'd3, win: 20, per: 8, lat: 1 + SETTLE_CYC + 20 * NWIN,
                    cmin: 2, cmax: 3, ovf: 1'b0, en: 4'b1000};

        RST = 1'b1; START = 1'b0; SEL = '0; WIN_LEN = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("reset ro_en", RO_EN, 0);
        check("reset busy_done", {BUSY, DONE}, 0);
        check("reset count", COUNT, 0);
        check("reset ovf", OVF, 0);

        for (int i = 0; i < 5; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // START re-pulsed mid-measurement with different SEL/WIN_LEN.
        set_periods(3'd1, 10);
        repeat (4) @(negedge CLK);
        issue_start(3'd1, 100);
        n = 0; dones = 0; first_done = 0; en_bad = 0;
        while (n < lat_main + 30) begin
            @(negedge CLK);
            n++;
            if (n == 50) begin
                START = 1'b1; SEL = 3'd0; WIN_LEN = 16'd5;
            end else if (n == 51) begin
                START = 1'b0;
            end
            if (DONE === 1'b1) begin
                dones++;
                if (first_done == 0) first_done = n;
            end else if (n < lat_main && RO_EN !== 4'b0010) begin
                en_bad++;
            end
        end
        check("restart done_count", dones, 1);
        check("restart done_latency", first_done, lat_main);
        check("restart ro_en", en_bad, 0);
        check_rng("restart count", COUNT, 9, 11);

        // Reset asserted in the middle of MEASURE aborts without DONE.
        issue_start(3'd1, 100);
        n = 0; dones = 0;
        while (n < 1 + SETTLE_CYC + 50) begin
            @(negedge CLK);
            n++;
            if (DONE === 1'b1) dones++;
        end
        check("abort busy_before", BUSY, 1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("abort ro_en", RO_EN, 0);
        check("abort count", COUNT, 0);
        check("abort busy_ovf", {BUSY, OVF}, 0);
        repeat (500) begin
            @(negedge CLK);
            if (DONE === 1'b1) dones++;
        end
        check("abort no_done", dones, 0);

        run_vec(vecs[0], "recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
